// File: rtl/mil_word_receiver.sv
// -----------------------------------------------------------------------------
// mil_word_receiver
//
// Decodes one MIL-STD-1553 Manchester-II differential line into 16-bit words.
// Each word is a 3H/3H sync (command/status starts POS, data starts NEG),
// 16 Manchester data bits MSB first, then one odd-parity bit. Good words are
// presented with a one-clock out_valid pulse; rejected words give a one-clock
// out_err pulse with a sticky error code. Back-to-back words with no gap are
// accepted: the first sample after the parity bit may already be the next sync.
//
// Ports:
//   clk           system clock
//   nRst          asynchronous active-low reset (clears everything, mid-word too)
//   RXin, nRXin   line legs, asynchronous to clk (2-FF synchronized here)
//   out_data      last good word
//   out_is_data   1 = data sync, 0 = command/status sync (for out_data)
//   out_valid     one-clock pulse, word accepted
//   out_err       one-clock pulse, word rejected
//   out_err_code  1 = sync timing, 2 = Manchester, 3 = parity; held until next error
//   out_busy      high whenever the receiver is not idle
//
// HALF_BIT_CLKS must be even and at least 8 so the two mid-half sample
// points are distinct and inside the bit.
// -----------------------------------------------------------------------------
module mil_word_receiver #(
    parameter int HALF_BIT_CLKS = 50,
    parameter int SYNC_TOL      = 10
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        RXin,
    input  logic        nRXin,
    output logic [15:0] out_data,
    output logic        out_is_data,
    output logic        out_valid,
    output logic        out_err,
    output logic [1:0]  out_err_code,
    output logic        out_busy
);

    localparam int H          = HALF_BIT_CLKS;
    localparam int SYNC_NOM   = 3 * H;
    localparam int SYNC_MAX_I = SYNC_NOM + SYNC_TOL;
    localparam int CNT_W      = $clog2(SYNC_MAX_I + 2 * H + 1);
    localparam int T_W        = $clog2(2 * H);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_MIN   = CNT_W'(SYNC_NOM - SYNC_TOL);
    localparam logic [CNT_W-1:0] SYNC_MAX   = CNT_W'(SYNC_MAX_I);
    localparam logic [CNT_W-1:0] SYNC_B_END = CNT_W'(SYNC_NOM - 1);
    localparam logic [CNT_W-1:0] IDLE_END   = CNT_W'(2 * H - 1);

    localparam logic [T_W-1:0] T_ONE  = T_W'(1);
    localparam logic [T_W-1:0] T_S1   = T_W'(H / 2);
    localparam logic [T_W-1:0] T_S2   = T_W'((3 * H) / 2);
    localparam logic [T_W-1:0] T_LAST = T_W'(2 * H - 1);

    localparam logic [4:0] K_PAR  = 5'd16;
    localparam logic [4:0] K_TAIL = 5'd17;

    // Line level encoded as {RXin, nRXin}; 00 and 11 are both "idle".
    localparam logic [1:0] LV_POS = 2'b10;
    localparam logic [1:0] LV_NEG = 2'b01;

    localparam logic [1:0] EC_SYNC = 2'd1;
    localparam logic [1:0] EC_MAN  = 2'd2;
    localparam logic [1:0] EC_PAR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC_A    = 3'd1,
        ST_SYNC_B    = 3'd2,
        ST_BITS      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers, one per leg
    // ------------------------------------------------------------------
    logic [1:0] line_raw;
    logic [1:0] line_meta_reg;
    logic [1:0] line_sync_reg;

    assign line_raw = {RXin, nRXin};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    line_meta_reg[gi] <= 1'b0;
                    line_sync_reg[gi] <= 1'b0;
                end else begin
                    line_meta_reg[gi] <= line_raw[gi];
                    line_sync_reg[gi] <= line_meta_reg[gi];
                end
            end
        end
    endgenerate

    logic [1:0] lvl;
    logic       lvl_idle;

    assign lvl      = line_sync_reg;
    assign lvl_idle = (lvl[1] == lvl[0]);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;     // sync-half / idle-run sample count
    logic [T_W-1:0]   t_reg, t_next;         // position within current bit
    logic [4:0]       k_reg, k_next;         // bit index; 16 = parity, 17 = tail cycle
    logic             pol_reg, pol_next;     // 1 = sync started POS
    logic [1:0]       s1_reg, s1_next;       // first-half sample of current bit
    logic [15:0]      shift_reg, shift_next;

    logic [15:0] data_reg;
    logic        is_data_reg;
    logic        valid_reg;
    logic        err_reg;
    logic [1:0]  err_code_reg;

    logic [1:0] lvl_first;
    logic [1:0] lvl_second;

    assign lvl_first  = pol_reg ? LV_POS : LV_NEG;
    assign lvl_second = pol_reg ? LV_NEG : LV_POS;

    // Combinational events produced by the next-state logic
    logic       word_ok;
    logic       err_fire;
    logic [1:0] err_code;
    logic       man_ok;
    logic       bit_val;

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            t_reg        <= '0;
            k_reg        <= '0;
            pol_reg      <= 1'b0;
            s1_reg       <= 2'b00;
            shift_reg    <= '0;
            data_reg     <= '0;
            is_data_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            t_reg     <= t_next;
            k_reg     <= k_next;
            pol_reg   <= pol_next;
            s1_reg    <= s1_next;
            shift_reg <= shift_next;
            valid_reg <= word_ok;
            err_reg   <= err_fire;
            if (err_fire) begin
                err_code_reg <= err_code;
            end
            if (word_ok) begin
                data_reg    <= shift_reg;
                is_data_reg <= ~pol_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath logic
    //
    // cnt counts samples of the current sync half taken before this cycle,
    // so a transition seen now measures a half of exactly cnt_reg clocks.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        t_next     = t_reg;
        k_next     = k_reg;
        pol_next   = pol_reg;
        s1_next    = s1_reg;
        shift_next = shift_reg;
        word_ok    = 1'b0;
        err_fire   = 1'b0;
        err_code   = 2'd0;
        man_ok     = 1'b0;
        bit_val    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!lvl_idle) begin
                    pol_next   = (lvl == LV_POS);
                    cnt_next   = CNT_ONE;
                    state_next = ST_SYNC_A;
                end
            end

            ST_SYNC_A: begin
                if (lvl == lvl_first) begin
                    if (cnt_reg >= SYNC_MAX) begin
                        err_fire = 1'b1;
                        err_code = EC_SYNC;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end else if (lvl == lvl_second) begin
                    if ((cnt_reg >= SYNC_MIN) && (cnt_reg <= SYNC_MAX)) begin
                        state_next = ST_SYNC_B;
                        cnt_next   = CNT_ONE;
                    end else begin
                        err_fire = 1'b1;
                        err_code = EC_SYNC;
                    end
                end else begin
                    err_fire = 1'b1;
                    err_code = EC_SYNC;
                end
            end

            ST_SYNC_B: begin
                // Bit timing is anchored to the mid-sync edge: bit 0 starts
                // exactly 3H samples after it.
                if ((lvl != lvl_second) && (cnt_reg < SYNC_MIN)) begin
                    err_fire = 1'b1;
                    err_code = EC_SYNC;
                end else if (cnt_reg == SYNC_B_END) begin
                    state_next = ST_BITS;
                    k_next     = '0;
                    t_next     = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_BITS: begin
                if (k_reg == K_TAIL) begin
                    // First sample after a good word: either the next
                    // word's sync has already begun, or the bus went idle.
                    if (!lvl_idle) begin
                        pol_next   = (lvl == LV_POS);
                        cnt_next   = CNT_ONE;
                        state_next = ST_SYNC_A;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (t_reg == T_LAST) begin
                        t_next = '0;
                        k_next = k_reg + 5'd1;
                    end else begin
                        t_next = t_reg + T_ONE;
                    end

                    if (t_reg == T_S1) begin
                        s1_next = lvl;
                    end

                    if (t_reg == T_S2) begin
                        man_ok  = ((s1_reg == LV_POS) && (lvl == LV_NEG)) ||
                                  ((s1_reg == LV_NEG) && (lvl == LV_POS));
                        bit_val = (s1_reg == LV_POS);
                        if (!man_ok) begin
                            err_fire = 1'b1;
                            err_code = EC_MAN;
                        end else if (k_reg == K_PAR) begin
                            if (^{shift_reg, bit_val}) begin
                                word_ok = 1'b1;
                            end else begin
                                err_fire = 1'b1;
                                err_code = EC_PAR;
                            end
                        end else begin
                            shift_next = {shift_reg[14:0], bit_val};
                        end
                    end
                end
            end

            ST_WAIT_IDLE: begin
                // Need an unbroken run of 2H idle samples before rearming.
                if (lvl_idle) begin
                    if (cnt_reg == IDLE_END) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end else begin
                    cnt_next = '0;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (err_fire) begin
            state_next = ST_WAIT_IDLE;
            cnt_next   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_data     = data_reg;
        out_is_data  = is_data_reg;
        out_valid    = valid_reg;
        out_err      = err_reg;
        out_err_code = err_code_reg;
        out_busy     = (state_reg != ST_IDLE);
    end

endmodule

// File: tb/tb_mil_word_receiver.sv
// -----------------------------------------------------------------------------
// Directed testbench for mil_word_receiver at default parameters
// (H = 50 clocks, sync tolerance 10). A behavioural transmitter drives the
// line on falling clock edges; a monitor logs every out_valid / out_err pulse
// with its cycle stamp; the main sequence checks the log and live outputs.
// -----------------------------------------------------------------------------
module tb_mil_word_receiver;

    localparam int H = 50;

    localparam logic [1:0] POS = 2'b10;
    localparam logic [1:0] NEG = 2'b01;
    localparam logic [1:0] IDL = 2'b00;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        RXin = 1'b0;
    logic        nRXin = 1'b0;
    logic [15:0] out_data;
    logic        out_is_data;
    logic        out_valid;
    logic        out_err;
    logic [1:0]  out_err_code;
    logic        out_busy;

    mil_word_receiver #(
        .HALF_BIT_CLKS(50),
        .SYNC_TOL     (10)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .RXin        (RXin),
        .nRXin       (nRXin),
        .out_data    (out_data),
        .out_is_data (out_is_data),
        .out_valid   (out_valid),
        .out_err     (out_err),
        .out_err_code(out_err_code),
        .out_busy    (out_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log
    logic [15:0] v_data_q[$];
    logic        v_is_q[$];
    int          v_cyc_q[$];
    logic [1:0]  e_code_q[$];
    int          e_cyc_q[$];
    int          both_cnt = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            v_data_q.push_back(out_data);
            v_is_q.push_back(out_is_data);
            v_cyc_q.push_back(cyc);
            $display("valid pulse: cycle %0d data 0x%04h is_data %0b", cyc, out_data, out_is_data);
        end
        if (out_err) begin
            e_code_q.push_back(out_err_code);
            e_cyc_q.push_back(cyc);
            $display("err pulse: cycle %0d code %0d", cyc, out_err_code);
        end
        if (out_valid && out_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] lv, input int n);
        {RXin, nRXin} = lv;
        repeat (n) @(negedge clk);
    endtask

    // Sends one word. hold_k >= 0 drives that bit POS for a whole bit time;
    // abort_k >= 0 stops (line idle) at the start of that bit.
    task automatic send_word(input logic is_data, input logic [15:0] data,
                             input logic flip_par, input int first_len,
                             input int hold_k, input int abort_k);
        logic [1:0] first_lv;
        logic [1:0] second_lv;
        logic       bitv;
        first_lv  = is_data ? NEG : POS;
        second_lv = is_data ? POS : NEG;
        drive(first_lv, first_len);
        mid_cyc = cyc;
        drive(second_lv, 3 * H);
        for (int k = 0; k < 17; k++) begin
            if (k == abort_k) begin
                {RXin, nRXin} = IDL;
                return;
            end
            bitv = (k < 16) ? data[15 - k] : ((~^data) ^ flip_par);
            if (k == hold_k) begin
                drive(POS, 2 * H);
            end else if (bitv) begin
                drive(POS, H);
                drive(NEG, H);
            end else begin
                drive(NEG, H);
                drive(POS, H);
            end
        end
        $display("sent word: data 0x%04h is_data %0b flip_par %0b first_len %0d hold_k %0d",
                 data, is_data, flip_par, first_len, hold_k);
    endtask

    int lat;

    initial begin
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid",    out_valid,    1'b0);
        check("rst_err",      out_err,      1'b0);
        check("rst_data",     out_data,     16'h0000);
        check("rst_is_data",  out_is_data,  1'b0);
        check("rst_err_code", out_err_code, 2'd0);
        check("rst_busy",     out_busy,     1'b0);
        nRst = 1'b1;
        drive(IDL, 20);

        // Command word 0x0001
        send_word(1'b0, 16'h0001, 1'b0, 3 * H, -1, -1);
        drive(IDL, 3 * H);
        check("t1_valid_cnt", v_data_q.size(), 1);
        check("t1_err_cnt",   e_code_q.size(), 0);
        check("t1_data",      v_data_q[0], 16'h0001);
        check("t1_is_data",   v_is_q[0],   1'b0);
        lat = v_cyc_q[0] - mid_cyc;
        $display("t1 latency from mid-sync edge: %0d", lat);
        check("t1_latency_1826_to_1830", (lat >= 1826 && lat <= 1830), 1'b1);
        check("t1_busy_after", out_busy, 1'b0);

        // Gapless data words 0x0002 then 0xAB45 (one word = 40H clocks)
        send_word(1'b1, 16'h0002, 1'b0, 3 * H, -1, -1);
        send_word(1'b1, 16'hAB45, 1'b0, 3 * H, -1, -1);
        drive(IDL, 3 * H);
        check("t2_valid_cnt", v_data_q.size(), 3);
        check("t2_err_cnt",   e_code_q.size(), 0);
        check("t2_data_a",    v_data_q[1], 16'h0002);
        check("t2_is_data_a", v_is_q[1],   1'b1);
        check("t2_data_b",    v_data_q[2], 16'hAB45);
        check("t2_is_data_b", v_is_q[2],   1'b1);
        check("t2_spacing",   v_cyc_q[2] - v_cyc_q[1], 40 * H);

        // Data word 0xFFA1 with inverted parity
        send_word(1'b1, 16'hFFA1, 1'b1, 3 * H, -1, -1);
        drive(IDL, 110);
        check("t3_err_cnt",   e_code_q.size(), 1);
        check("t3_err_code",  e_code_q[0], 2'd3);
        check("t3_code_held", out_err_code, 2'd3);
        check("t3_valid_cnt", v_data_q.size(), 3);
        check("t3_data_kept", out_data, 16'hAB45);
        check("t3_busy",      out_busy, 1'b0);

        // Bit 5 held POS for a full bit time: error at its second sample
        send_word(1'b1, 16'h00FF, 1'b0, 3 * H, 5, -1);
        drive(IDL, 110);
        check("t4_err_cnt",   e_code_q.size(), 2);
        check("t4_err_code",  e_code_q[1], 2'd2);
        check("t4_err_time",  e_cyc_q[1] - mid_cyc, 2 + 3 * H + 10 * H + (3 * H) / 2 + 1);
        check("t4_valid_cnt", v_data_q.size(), 3);
        check("t4_busy",      out_busy, 1'b0);

        // Short first sync half (100 clocks), then a good command word 0x1234
        send_word(1'b0, 16'h0000, 1'b0, 100, -1, 0);
        drive(IDL, 150);
        check("t5_err_cnt",   e_code_q.size(), 3);
        check("t5_err_code",  e_code_q[2], 2'd1);
        check("t5_busy",      out_busy, 1'b0);
        send_word(1'b0, 16'h1234, 1'b0, 3 * H, -1, -1);
        drive(IDL, 3 * H);
        check("t5_valid_cnt", v_data_q.size(), 4);
        check("t5_data",      v_data_q[3], 16'h1234);
        check("t5_is_data",   v_is_q[3],   1'b0);
        check("t5_err_cnt_after", e_code_q.size(), 3);

        // Reset for 20 ns at the start of bit 8
        send_word(1'b1, 16'h0F0F, 1'b0, 3 * H, -1, 8);
        check("t6_busy_midword", out_busy, 1'b1);
        @(posedge clk);
        #2;
        nRst = 1'b0;
        #1;
        check("t6_rst_valid",    out_valid,    1'b0);
        check("t6_rst_err",      out_err,      1'b0);
        check("t6_rst_data",     out_data,     16'h0000);
        check("t6_rst_is_data",  out_is_data,  1'b0);
        check("t6_rst_err_code", out_err_code, 2'd0);
        check("t6_rst_busy",     out_busy,     1'b0);
        #19;
        nRst = 1'b1;
        @(negedge clk);
        drive(IDL, 200);
        check("t6_no_pulse_valid", v_data_q.size(), 4);
        check("t6_no_pulse_err",   e_code_q.size(), 3);
        send_word(1'b1, 16'h0F0F, 1'b0, 3 * H, -1, -1);
        drive(IDL, 3 * H);
        check("t6_valid_cnt", v_data_q.size(), 5);
        check("t6_data",      v_data_q[4], 16'h0F0F);
        check("t6_is_data",   v_is_q[4],   1'b1);
        check("t6_err_cnt",   e_code_q.size(), 3);

        check("valid_err_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
